// File: rtl/dccm.sv
// Data closely-coupled memory: registered reads, byte-strobed writes,
// write-first bypass, range checks and a zeroing sweep after reset.
module dccm #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 1024
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] dccm_raddr,
  input  logic            dccm_rvalid_in,
  output logic [XLEN-1:0] dccm_rdata,
  output logic            dccm_rvalid_out,
  input  logic [XLEN-1:0] dccm_waddr,
  input  logic            dccm_wen,
  input  logic [XLEN-1:0] dccm_wdata,
  input  logic [3:0]      dccm_wstrb,
  output logic            dccm_ready,
  output logic            dccm_rd_err,
  output logic            dccm_wr_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int NB = XLEN / 8;

  typedef enum logic {INIT, RUN} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] mem [DEPTH];

  logic [XLEN-1:0] rdata_q, rdata_d;
  logic            rvalid_q;
  logic            rd_err_q;
  logic            wr_err_q;

  logic [AW-1:0]   ridx, widx;
  logic            r_oor, w_oor;
  logic            run;
  logic            rd_acc, wr_acc;
  logic [XLEN-1:0] rword;
  logic            unused_lo;

  assign ridx  = dccm_raddr[AW+1:2];
  assign widx  = dccm_waddr[AW+1:2];
  assign r_oor = |dccm_raddr[XLEN-1:AW+2];
  assign w_oor = |dccm_waddr[XLEN-1:AW+2];
  assign unused_lo = ^{dccm_raddr[1:0], dccm_waddr[1:0]};

  assign run    = (state_q == RUN) && !rst;
  assign rd_acc = run && dccm_rvalid_in;
  assign wr_acc = run && dccm_wen && !w_oor;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == INIT) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == AW'(DEPTH - 1)) begin
        state_d = RUN;
      end
    end
  end

  // Write-first: strobed lanes of a same-index write override the array.
  always_comb begin
    rword = mem[ridx];
    for (int i = 0; i < NB; i++) begin
      if (wr_acc && (widx == ridx) && dccm_wstrb[i]) begin
        rword[8*i +: 8] = dccm_wdata[8*i +: 8];
      end
    end
    rdata_d = r_oor ? '0 : rword;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= INIT;
      cnt_q    <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      rd_err_q <= 1'b0;
      wr_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rvalid_q <= rd_acc;
      rd_err_q <= rd_acc && r_oor;
      wr_err_q <= run && dccm_wen && w_oor;
      if (rd_acc) begin
        rdata_q <= rdata_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && (state_q == INIT)) begin
      mem[cnt_q] <= '0;
    end else if (wr_acc) begin
      for (int i = 0; i < NB; i++) begin
        if (dccm_wstrb[i]) begin
          mem[widx][8*i +: 8] <= dccm_wdata[8*i +: 8];
        end
      end
    end
  end

  assign dccm_rdata      = rdata_q;
  assign dccm_rvalid_out = rvalid_q;
  assign dccm_rd_err     = rd_err_q;
  assign dccm_wr_err     = wr_err_q;
  assign dccm_ready      = (state_q == RUN);

endmodule

// File: tb/tb_dccm.sv
// Directed bench for dccm at DEPTH=16: init sweep, R/W, strobes,
// bypass, range errors and reset during RUN.
module tb_dccm;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] raddr;
  logic        ren;
  logic [31:0] rdata;
  logic        rvalid;
  logic [31:0] waddr;
  logic        wen;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        ready;
  logic        rd_err;
  logic        wr_err;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dccm #(.XLEN(32), .DEPTH(16)) dut (
    .clk(clk),
    .rst(rst),
    .dccm_raddr(raddr),
    .dccm_rvalid_in(ren),
    .dccm_rdata(rdata),
    .dccm_rvalid_out(rvalid),
    .dccm_waddr(waddr),
    .dccm_wen(wen),
    .dccm_wdata(wdata),
    .dccm_wstrb(wstrb),
    .dccm_ready(ready),
    .dccm_rd_err(rd_err),
    .dccm_wr_err(wr_err)
  );

  typedef struct {
    string       nm;
    logic        ren;
    logic [31:0] ra;
    logic        wen;
    logic [31:0] wa;
    logic [31:0] wd;
    logic [3:0]  ws;
    logic        ev;
    logic [31:0] ed;
    logic        ere;
    logic        ewe;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ren = 1'b0; raddr = '0;
    wen = 1'b0; waddr = '0; wdata = '0; wstrb = '0;
  endtask

  task automatic add(input string nm, input logic r, input logic [31:0] ra,
                     input logic w, input logic [31:0] wa,
                     input logic [31:0] wd, input logic [3:0] ws,
                     input logic ev, input logic [31:0] ed,
                     input logic ere, input logic ewe);
    vec_t v;
    v.nm = nm; v.ren = r; v.ra = ra; v.wen = w; v.wa = wa;
    v.wd = wd; v.ws = ws; v.ev = ev; v.ed = ed; v.ere = ere; v.ewe = ewe;
    tbl.push_back(v);
  endtask

  task automatic sweep(input string tag);
    for (int k = 1; k <= 16; k++) begin
      ren = 1'b1; raddr = 32'h3C;
      step();
      chk({tag, "_ready"}, 32'(ready), 32'(k == 16));
      chk({tag, "_rvalid"}, 32'(rvalid), 32'h0);
    end
    idle();
  endtask

  initial begin
    idle();
    rst = 1'b1;
    add("rd3c",    1, 32'h3C, 0, 0, 0, 0, 1, 32'h00000000, 0, 0);
    add("wr10",    0, 0, 1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 32'h00000000, 0, 0);
    add("rd10",    1, 32'h10, 0, 0, 0, 0, 1, 32'hDEADBEEF, 0, 0);
    add("rd13",    1, 32'h13, 0, 0, 0, 0, 1, 32'hDEADBEEF, 0, 0);
    add("wrstrb",  0, 0, 1, 32'h10, 32'h11223344, 4'h5, 0, 32'hDEADBEEF, 0, 0);
    add("rdstrb",  1, 32'h10, 0, 0, 0, 0, 1, 32'hDE22BE44, 0, 0);
    add("wr20",    0, 0, 1, 32'h20, 32'hAAAAAAAA, 4'hF, 0, 32'hDE22BE44, 0, 0);
    add("bypass",  1, 32'h20, 1, 32'h20, 32'h55555555, 4'h3, 1, 32'hAAAA5555, 0, 0);
    add("rd20",    1, 32'h20, 0, 0, 0, 0, 1, 32'hAAAA5555, 0, 0);
    add("wr04",    0, 0, 1, 32'h04, 32'hCAFEF00D, 4'hF, 0, 32'hAAAA5555, 0, 0);
    add("rdoor",   1, 32'h40, 0, 0, 0, 0, 1, 32'h00000000, 1, 0);
    add("wroor",   0, 0, 1, 32'h44, 32'h12345678, 4'hF, 0, 32'h00000000, 0, 1);
    add("rd04",    1, 32'h04, 0, 0, 0, 0, 1, 32'hCAFEF00D, 0, 0);
    add("indep",   1, 32'h10, 1, 32'h14, 32'h00000077, 4'h1, 1, 32'hDE22BE44, 0, 0);
    add("rd14",    1, 32'h14, 0, 0, 0, 0, 1, 32'h00000077, 0, 0);
    add("strb0",   0, 0, 1, 32'h10, 32'hFFFFFFFF, 4'h0, 0, 32'h00000077, 0, 0);
    add("rdnoop",  1, 32'h10, 0, 0, 0, 0, 1, 32'hDE22BE44, 0, 0);
    add("rdwroor", 1, 32'h3C, 1, 32'h80, 32'hFFFFFFFF, 4'hF, 1, 32'h00000000, 0, 1);
    add("rd00",    1, 32'h00, 0, 0, 0, 0, 1, 32'h00000000, 0, 0);
    add("rdhigh",  1, 32'h80000010, 0, 0, 0, 0, 1, 32'h00000000, 1, 0);

    for (int i = 0; i < 3; i++) step();
    chk("rst_ready", 32'(ready), 32'h0);
    chk("rst_rvalid", 32'(rvalid), 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_err", 32'({rd_err, wr_err}), 32'h0);
    rst = 1'b0;
    sweep("init");

    foreach (tbl[i]) begin
      ren = tbl[i].ren; raddr = tbl[i].ra;
      wen = tbl[i].wen; waddr = tbl[i].wa;
      wdata = tbl[i].wd; wstrb = tbl[i].ws;
      step();
      chk({tbl[i].nm, "_rvalid"}, 32'(rvalid), 32'(tbl[i].ev));
      chk({tbl[i].nm, "_rdata"}, rdata, tbl[i].ed);
      chk({tbl[i].nm, "_rderr"}, 32'(rd_err), 32'(tbl[i].ere));
      chk({tbl[i].nm, "_wrerr"}, 32'(wr_err), 32'(tbl[i].ewe));
      chk({tbl[i].nm, "_ready"}, 32'(ready), 32'h1);
    end

    idle();
    rst = 1'b1; ren = 1'b1; raddr = 32'h10;
    step();
    chk("mrst_rvalid", 32'(rvalid), 32'h0);
    chk("mrst_ready", 32'(ready), 32'h0);
    chk("mrst_rdata", rdata, 32'h0);
    rst = 1'b0;
    idle();
    sweep("reinit");
    ren = 1'b1; raddr = 32'h10;
    step();
    chk("post_rvalid", 32'(rvalid), 32'h1);
    chk("post_rdata", rdata, 32'h0);
    idle();
    step();
    chk("post_pulse", 32'(rvalid), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
